bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Multi-digit, parametrised timer: a chain of NUM_DIGITS 4-bit digits, each with its own maximum value, stepped by rising edges of a slow `step` strobe. Counts up or down, latches a reload value, and either auto-reloads or holds at the terminal count on underflow/overflow. It replaces single-digit timers chained by hand in the display/timekeeping path (mm:ss clocks, kitchen timers) and drives the 7-segment decoders directly.

## Interface
- NUM_DIGITS, 4, number of digits in the chain (1..8)
- DIGIT_MAX, 16'h5959, packed per-digit maxima (4 bits each, digit 0 in bits [3:0]); default gives mm:ss

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  step rising edges are counted only while high
- step  in  1  count strobe, level; rising edge detected internally
- dir  in  1  0 = count down, 1 = count up
- load  in  1  load `load_value` into count and reload register
- load_value  in  4*NUM_DIGITS  value to load, digit i in bits [4i+3:4i]
- reload_en  in  1  1 = auto-reload on terminal step, 0 = hold
- count_out  out  4*NUM_DIGITS  current count
- done  out  1  combinational: count equals terminal value for current `dir`
- expired  out  1  registered one-cycle pulse on a terminal step
- holding  out  1  high while in HOLD state

## Operation
- Terminal value: all digits 0 when dir=0; every digit equal to its DIGIT_MAX when dir=1.
- Edge detect: `step_q` registers `step` every cycle regardless of enable/load/state; step_rise = step & ~step_q.
- Load: each digit clamped independently: digit > its max -> max. Clamped value written to count and to reload register; state -> RUN.
- States: RUN, HOLD. Reset -> RUN.
- In RUN, on step_rise & enable:
  - count not terminal: down = decrement with borrow (digit 0 -> its max, borrow to next digit); up = increment with carry (digit at max -> 0, carry to next digit).
  - count terminal: `expired` pulses; reload_en=1 -> count := reload register, stay RUN; reload_en=0 -> count unchanged, state -> HOLD.
- In HOLD: step edges ignored, count frozen; only load or reset exit to RUN.
- Digit values above their max never appear on count_out.
- Priority: reset > load > step.

## Timing
- Reset values: count_out 0, reload register 0, expired 0, holding 0, step_q 0, state RUN; done = 1 after reset if dir=0.
- Load sampled at edge N: count_out valid after edge N. Latency 1.
- Step rise: step high at edge N with step_q low -> count updated at edge N; a step held high counts once.
- expired: high for exactly the one cycle after the terminal-step edge; never high two cycles in a row.
- Load and step_rise in the same cycle: load wins, edge is consumed (not replayed).
- Step rising while enable low: edge lost; raising enable while step stays high does not count.
- dir change: done updates combinationally; the next step uses the new direction.
- Reset mid-count or in HOLD: all state returns to reset values at that edge.

## Test plan
- Reset, load 16'h0130, dir=0, 3 step pulses -> count 0129, 0128, 0127; clamp: load 16'h7A9F -> count 5959.
- Load 16'h0001, reload_en=0, dir=0: step -> 0000, done=1; step -> expired one cycle, holding=1; 2 more steps -> count stays 0000; load 16'h0010 -> holding=0, count 0010.
- Load 16'h0002, reload_en=1, dir=0: 3 steps -> 0001, 0000, then 0002 with expired pulse on the third.
- dir=1 from 16'h5958: step -> 5959 (done=1); step with reload_en=1 and reload register 0 -> 0000, expired pulse.
- Step held high 10 cycles -> one decrement; enable low during rise then high while step high -> no count; load and step rise in the same cycle -> count equals load value.
- Assert reset while in HOLD with expired pending -> count 0000, holding 0, expired 0 next cycle.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Chained multi-digit BCD up/down timer with per-digit maxima, load clamping,
// and auto-reload or hold on terminal count. Feeds 7-segment decoders directly.
module bcd_countdown_timer #(
   parameter int                      NUM_DIGITS = 4,
   parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h5959
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    step,
   input  logic                    dir,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    reload_en,
   output logic [4*NUM_DIGITS-1:0] count_out,
   output logic                    done,
   output logic                    expired,
   output logic                    holding
);

   localparam int W = 4 * NUM_DIGITS;

   typedef enum logic {RUN, HOLD} state_t;

   state_t         state, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   reload_q, reload_d;
   logic [W-1:0]   load_clamped, count_step;
   logic           step_q, step_rise, expired_d, at_terminal, chain;

   assign step_rise   = step & ~step_q;
   assign at_terminal = dir ? (count_q == DIGIT_MAX) : (count_q == '0);

   // Per-digit clamp of the load value and the ripple borrow/carry step.
   // chain stays high only while every lower digit wrapped around.
   always_comb begin
      load_clamped = '0;
      count_step   = count_q;
      chain        = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         load_clamped[4*i +: 4] = (load_value[4*i +: 4] > DIGIT_MAX[4*i +: 4]) ?
                                  DIGIT_MAX[4*i +: 4] : load_value[4*i +: 4];
         if (chain) begin
            if (dir) begin
               if (count_q[4*i +: 4] >= DIGIT_MAX[4*i +: 4]) begin
                  count_step[4*i +: 4] = 4'd0;
               end else begin
                  count_step[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                  chain                = 1'b0;
               end
            end else begin
               if (count_q[4*i +: 4] == 4'd0) begin
                  count_step[4*i +: 4] = DIGIT_MAX[4*i +: 4];
               end else begin
                  count_step[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                  chain                = 1'b0;
               end
            end
         end
      end
   end

   // Load always wins over a simultaneous step edge; the edge is consumed.
   always_comb begin
      state_d   = state;
      count_d   = count_q;
      reload_d  = reload_q;
      expired_d = 1'b0;
      if (load) begin
         count_d  = load_clamped;
         reload_d = load_clamped;
         state_d  = RUN;
      end else begin
         case (state)
            RUN: begin
               if (step_rise && enable) begin
                  if (at_terminal) begin
                     expired_d = 1'b1;
                     if (reload_en) begin
                        count_d = reload_q;
                     end else begin
                        state_d = HOLD;
                     end
                  end else begin
                     count_d = count_step;
                  end
               end
            end
            HOLD: begin
               state_d = HOLD;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         count_q  <= '0;
         reload_q <= '0;
         expired  <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         state    <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         expired  <= expired_d;
         step_q   <= step;
      end
   end

   assign count_out = count_q;
   assign done      = at_terminal;
   assign holding   = (state == HOLD);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (mm:ss default): expected values are
// queued as stimulus is driven, DUT samples are queued, each test compares both.
module tb_bcd_countdown_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        step;
   logic        dir;
   logic        load;
   logic [15:0] load_value;
   logic        reload_en;
   logic [15:0] count_out;
   logic        done;
   logic        expired;
   logic        holding;

   typedef struct {
      logic [18:0] v;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   logic [18:0] obs_q[$];
   int          errors = 0;
   int          checks = 0;

   bcd_countdown_timer #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5959)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .step       (step),
      .dir        (dir),
      .load       (load),
      .load_value (load_value),
      .reload_en  (reload_en),
      .count_out  (count_out),
      .done       (done),
      .expired    (expired),
      .holding    (holding)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic expect_val(input logic [15:0] c, input logic d, input logic e,
                             input logic h, input string t);
      exp_t x;
      x.v   = {c, d, e, h};
      x.tag = t;
      exp_q.push_back(x);
   endtask

   task automatic sample();
      obs_q.push_back({count_out, done, expired, holding});
   endtask

   task automatic do_load(input logic [15:0] v);
      load       = 1'b1;
      load_value = v;
      cyc();
      load       = 1'b0;
   endtask

   // One low cycle so the edge detector re-arms, then one high cycle.
   task automatic do_step();
      step = 1'b0;
      cyc();
      step = 1'b1;
      cyc();
      step = 1'b0;
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [18:0] o;
      reset = 1'b1;
      cyc();
      cyc();
      expect_val(16'h0000, 1, 0, 0, "reset_held");
      sample();
      reset = 1'b0;
      cyc();
      expect_val(16'h0000, 1, 0, 0, "reset_released");
      sample();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   task automatic test_countdown_clamp();
      exp_t        e;
      logic [18:0] o;
      dir = 1'b0;
      do_load(16'h0130);
      expect_val(16'h0130, 0, 0, 0, "load_0130");
      sample();
      do_step();
      expect_val(16'h0129, 0, 0, 0, "down_0129");
      sample();
      do_step();
      expect_val(16'h0128, 0, 0, 0, "down_0128");
      sample();
      do_step();
      expect_val(16'h0127, 0, 0, 0, "down_0127");
      sample();
      do_load(16'h7A9F);
      expect_val(16'h5959, 0, 0, 0, "clamp_7A9F");
      sample();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   task automatic test_hold();
      exp_t        e;
      logic [18:0] o;
      dir       = 1'b0;
      reload_en = 1'b0;
      do_load(16'h0001);
      expect_val(16'h0001, 0, 0, 0, "hold_load");
      sample();
      do_step();
      expect_val(16'h0000, 1, 0, 0, "hold_reach0");
      sample();
      do_step();
      expect_val(16'h0000, 1, 1, 1, "hold_expire");
      sample();
      cyc();
      expect_val(16'h0000, 1, 0, 1, "hold_expire_drop");
      sample();
      for (int i = 0; i < 2; i++) begin
         do_step();
         expect_val(16'h0000, 1, 0, 1, "hold_frozen");
         sample();
      end
      do_load(16'h0010);
      expect_val(16'h0010, 0, 0, 0, "hold_exit_load");
      sample();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   task automatic test_reload();
      exp_t        e;
      logic [18:0] o;
      dir       = 1'b0;
      reload_en = 1'b1;
      do_load(16'h0002);
      expect_val(16'h0002, 0, 0, 0, "reload_load");
      sample();
      do_step();
      expect_val(16'h0001, 0, 0, 0, "reload_0001");
      sample();
      do_step();
      expect_val(16'h0000, 1, 0, 0, "reload_0000");
      sample();
      do_step();
      expect_val(16'h0002, 0, 1, 0, "reload_wrap");
      sample();
      cyc();
      expect_val(16'h0002, 0, 0, 0, "reload_pulse_end");
      sample();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   // Count up from 00:00 to 59:58 so the reload register holds 0000.
   task automatic test_count_up();
      exp_t        e;
      logic [18:0] o;
      reload_en = 1'b1;
      dir       = 1'b1;
      do_load(16'h0000);
      expect_val(16'h0000, 0, 0, 0, "up_start");
      sample();
      for (int i = 0; i < 3598; i++) begin
         do_step();
         if (i == 59) begin
            expect_val(16'h0100, 0, 0, 0, "up_carry_0100");
            sample();
         end
      end
      expect_val(16'h5958, 0, 0, 0, "up_5958");
      sample();
      do_step();
      expect_val(16'h5959, 1, 0, 0, "up_5959");
      sample();
      do_step();
      expect_val(16'h0000, 0, 1, 0, "up_reload0");
      sample();
      dir = 1'b0;
      #1;
      expect_val(16'h0000, 1, 1, 0, "dir_flip_done");
      sample();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   task automatic test_step_edge();
      exp_t        e;
      logic [18:0] o;
      cyc();
      dir       = 1'b0;
      reload_en = 1'b0;
      do_load(16'h0050);
      expect_val(16'h0050, 0, 0, 0, "edge_load");
      sample();
      step = 1'b1;
      repeat (10) cyc();
      step = 1'b0;
      cyc();
      expect_val(16'h0049, 0, 0, 0, "edge_held_once");
      sample();
      enable = 1'b0;
      step   = 1'b1;
      cyc();
      cyc();
      enable = 1'b1;
      repeat (3) cyc();
      step = 1'b0;
      cyc();
      expect_val(16'h0049, 0, 0, 0, "edge_lost_disabled");
      sample();
      load       = 1'b1;
      load_value = 16'h0033;
      step       = 1'b1;
      cyc();
      load = 1'b0;
      expect_val(16'h0033, 0, 0, 0, "load_beats_step");
      sample();
      cyc();
      cyc();
      expect_val(16'h0033, 0, 0, 0, "edge_not_replayed");
      sample();
      step = 1'b0;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   task automatic test_reset_in_hold();
      exp_t        e;
      logic [18:0] o;
      dir       = 1'b0;
      reload_en = 1'b0;
      do_load(16'h0042);
      expect_val(16'h0042, 0, 0, 0, "midcount_load");
      sample();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      expect_val(16'h0000, 1, 0, 0, "midcount_reset");
      sample();
      do_load(16'h0001);
      do_step();
      do_step();
      expect_val(16'h0000, 1, 1, 1, "hold_pending");
      sample();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      expect_val(16'h0000, 1, 0, 0, "hold_reset");
      sample();
      cyc();
      expect_val(16'h0000, 1, 0, 0, "hold_reset_after");
      sample();
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.v) begin
            errors++;
            $display("[TB] FAIL %s: got count=%h dEh=%b want count=%h dEh=%b",
                     e.tag, o[18:3], o[2:0], e.v[18:3], e.v[2:0]);
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b1;
      step       = 1'b0;
      dir        = 1'b0;
      load       = 1'b0;
      load_value = 16'h0000;
      reload_en  = 1'b0;
      test_reset();
      test_countdown_clamp();
      test_hold();
      test_reload();
      test_count_up();
      test_step_edge();
      test_reset_in_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
